fpu_div_seq: RTL and testbench
==============================

# fpu_div_seq

Parametrised iterative IEEE-754 divider: a successor to the fixed-format FP16 divide coprocessor. Exponent and fraction widths are set by parameters, and it adds four rounding modes, exception flags and a busy/done handshake. It computes one quotient bit per cycle with a restoring divider and has fixed latency for every operand class. It sits beside the other FPU coprocessors and is started by the FPU issue logic.

## Interface
- EXPW, default 5: exponent width in bits (at least 3).
- FRACW, default 10: stored fraction width in bits (at least 2).
- W = 1+EXPW+FRACW (derived localparam): operand width; BIAS = 2^(EXPW-1)-1; N = FRACW+3.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- a  in  W  dividend {sign, exp, frac}; captured when start is accepted.
- b  in  W  divisor; captured when start is accepted.
- rm  in  2  rounding mode, captured when start is accepted:
  - 00 RNE (round to nearest, ties to even)
  - 01 RTZ (toward zero)
  - 10 RDN (toward −∞)
  - 11 RUP (toward +∞)
- busy  out  1  high from the cycle after acceptance until done rises.
- done  out  1  one-cycle pulse; result and flags are valid from this cycle.
- result  out  W  quotient; held until the next accepted start.
- flags  out  5  {invalid, divzero, overflow, underflow, inexact}; held with result.

## Operation
- States: IDLE, PREP, ITER, ROUND, DONE.
  - IDLE: start=1 at an edge latches a, b and rm, then moves to PREP.
  - PREP: one cycle. Classify operands, form the significands and compute the biased exponent. Move to ITER.
  - ITER: exactly N cycles, counted by a counter, then move to ROUND.
  - ROUND: one cycle, then DONE.
  - DONE: one cycle with done=1, then IDLE.
- start is ignored in every state except IDLE. Input changes after acceptance have no effect.
- Subnormal inputs (exp=0, frac≠0) are flushed to signed zero before classification (FTZ). Subnormals are never produced.
- Sign of the result is sA^sB for every class except NaN.
- Significands are mA = {1, fracA} and mB = {1, fracB}. Restoring division produces N quotient bits of mA/mB. The sticky bit is the OR of the final remainder being nonzero.
- Exponent path:
  - Width is EXPW+2, signed: e = eA − eB + BIAS.
  - If the first quotient bit is 0 (mA<mB), shift left by 1 and set e = e − 1.
- Rounding uses guard, round and sticky bits according to rm.
  - A mantissa carry-out renormalises and increments e.
  - inexact = guard|round|sticky.
- After rounding:
  - e ≥ 2^EXPW−1 is overflow. Set overflow=1 and inexact=1. Result is ±inf under RNE, or under a directed mode that rounds away from zero. Otherwise the result is ±max-finite ({exp=2^EXPW−2, frac all ones}).
  - e ≤ 0 is underflow. Result is signed zero with underflow=1 and inexact=1.
- Special classes are decided in PREP, override the datapath result, and keep the same latency. Canonical qNaN = {0, all-ones exp, 1, zeros}.
  - Either input NaN → qNaN. invalid=1 if that NaN is signalling (frac MSB=0).
  - 0/0 or inf/inf → qNaN, invalid=1.
  - finite nonzero/0 → signed inf, divzero=1.
  - inf/finite → signed inf, no flags.
  - finite/inf or 0/nonzero → signed zero, no flags.

## Timing
- If start is accepted at edge k, done=1 during the cycle after edge k+N+2.
- Latency is N+3 cycles: 16 for FP16.
- busy rises after edge k and falls in the cycle where done rises.
- start may be asserted in the DONE cycle's following IDLE cycle, giving back-to-back throughput of one operation per N+4 cycles.
- Reset values, forced immediately and asynchronously: state=IDLE, busy=0, done=0, result=0, flags=0, counter=0.
- Reset asserted mid-operation aborts it. No done is produced for the aborted operation.
- After release, the block first samples start at the next rising edge.

## Test plan
- 0x4600 / 0x4000, rm=00 → result 0x4200, flags 00000. done observed exactly 16 cycles after start, with busy high in between.
- 0x3C00 / 0x4200 (1/3):
  - rm=00 → 0x3555, flags 00001.
  - rm=01 → 0x3555.
  - rm=11 → 0x3556.
  - 0xBC00 / 0x4200, rm=10 → 0xB556.
- Specials:
  - 0x3C00 / 0x0000 → 0x7C00, flags 01000.
  - 0x0000 / 0x0000 → 0x7E00, flags 10000.
  - 0x7D00 / 0x3C00 → 0x7E00, flags 10000.
  - 0x7C00 / 0x4000 → 0x7C00, flags 00000.
- Range:
  - 0x7BFF / 0x1400, rm=00 → 0x7C00, flags 00101.
  - Same operands, rm=01 → 0x7BFF.
  - 0x0400 / 0x7800 → 0x0000, flags 00011.
  - Subnormal dividend 0x0001 / 0x3C00 → 0x0000, flags 00000.
- Handshake:
  - Pulse start with new operands every cycle while busy → only the first operation completes, with the first operands.
  - Start back-to-back in the IDLE cycle after done → second done follows N+3 cycles later.
- Reset asserted at ITER cycle 5 → outputs zero immediately and no done appears. A fresh start after release completes normally with the correct result.

Source files
------------

// File: rtl/fpu_div_seq.sv
// ============================================================================
//  Module   : fpu_div_seq
//  Purpose  : Iterative IEEE-754 divider, one restoring quotient bit per
//             cycle, four rounding modes, exception flags, fixed latency.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fpu_div_seq #(
  parameter int EXPW  = 5,
  parameter int FRACW = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [EXPW+FRACW:0]    a,
  input  logic [EXPW+FRACW:0]    b,
  input  logic [1:0]             rm,
  output logic                   busy,
  output logic                   done,
  output logic [EXPW+FRACW:0]    result,
  output logic [4:0]             flags
);

  localparam int c_w  = 1 + EXPW + FRACW;
  localparam int c_n  = FRACW + 3;
  localparam int c_cw = $clog2(c_n + 1);
  localparam logic signed [EXPW+1:0] c_bias = (EXPW+2)'((1 << (EXPW-1)) - 1);
  localparam logic signed [EXPW+1:0] c_emax = (EXPW+2)'((1 << EXPW) - 1);
  localparam logic [c_cw-1:0]        c_last = c_cw'(c_n - 1);
  localparam logic [c_w-1:0]         c_qnan = {1'b0, {EXPW{1'b1}}, 1'b1, {(FRACW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_ITER  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [c_w-1:0]          r_a, r_b, r_result, r_spec_res;
  logic [1:0]              r_rm;
  logic [c_cw-1:0]         r_cnt;
  logic [FRACW+1:0]        r_rem;
  logic [FRACW:0]          r_mb;
  logic [c_n-1:0]          r_q;
  logic signed [EXPW+1:0]  r_exp;
  logic                    r_sign, r_special;
  logic [4:0]              r_flags, r_spec_flags;

  // Operand classification (subnormals flush to zero via exp==0)
  logic [EXPW-1:0]  w_ea, w_eb;
  logic [FRACW-1:0] w_fa, w_fb;
  logic w_za, w_zb, w_ia, w_ib, w_na, w_nb, w_sna, w_snb, w_sign;

  assign w_ea   = r_a[c_w-2:FRACW];
  assign w_eb   = r_b[c_w-2:FRACW];
  assign w_fa   = r_a[FRACW-1:0];
  assign w_fb   = r_b[FRACW-1:0];
  assign w_za   = (w_ea == '0);
  assign w_zb   = (w_eb == '0);
  assign w_ia   = (&w_ea) & (w_fa == '0);
  assign w_ib   = (&w_eb) & (w_fb == '0);
  assign w_na   = (&w_ea) & (|w_fa);
  assign w_nb   = (&w_eb) & (|w_fb);
  assign w_sna  = w_na & ~w_fa[FRACW-1];
  assign w_snb  = w_nb & ~w_fb[FRACW-1];
  assign w_sign = r_a[c_w-1] ^ r_b[c_w-1];

  logic                   w_special;
  logic [c_w-1:0]         w_spec_res;
  logic [4:0]             w_spec_flags;
  logic signed [EXPW+1:0] w_exp0;

  assign w_exp0 = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + c_bias;

  always_comb begin
    w_special    = 1'b1;
    w_spec_res   = {w_sign, {(c_w-1){1'b0}}};
    w_spec_flags = 5'b00000;
    if (w_na | w_nb) begin
      w_spec_res      = c_qnan;
      w_spec_flags[4] = w_sna | w_snb;
    end else if ((w_za & w_zb) | (w_ia & w_ib)) begin
      w_spec_res   = c_qnan;
      w_spec_flags = 5'b10000;
    end else if (w_ia) begin
      w_spec_res = {w_sign, {EXPW{1'b1}}, {FRACW{1'b0}}};
    end else if (w_zb) begin
      w_spec_res   = {w_sign, {EXPW{1'b1}}, {FRACW{1'b0}}};
      w_spec_flags = 5'b01000;
    end else if (!(w_ib | w_za)) begin
      w_special = 1'b0;
    end
  end

  // Restoring step: the partial remainder always stays below 2*mB
  logic             w_ge;
  logic [FRACW+1:0] w_diff, w_rem_nxt;

  assign w_ge      = (r_rem >= {1'b0, r_mb});
  assign w_diff    = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign w_rem_nxt = {w_diff[FRACW:0], 1'b0};

  // Normalise and round; round and sticky are only ever used ORed together
  logic                   w_msb, w_guard, w_rs, w_inc, w_inexact, w_ovf, w_unf, w_to_inf;
  logic [FRACW:0]         w_mant;
  logic [FRACW+1:0]       w_mant_r;
  logic signed [EXPW+1:0] w_exp_n, w_exp_r;
  logic [c_w-1:0]         w_res;
  logic [4:0]             w_flg;

  assign w_msb     = r_q[c_n-1];
  assign w_mant    = w_msb ? r_q[c_n-1:2] : r_q[c_n-2:1];
  assign w_guard   = w_msb ? r_q[1] : r_q[0];
  assign w_rs      = (w_msb & r_q[0]) | (|r_rem);
  assign w_exp_n   = w_msb ? r_exp : (r_exp - (EXPW+2)'(1));
  assign w_inexact = w_guard | w_rs;

  always_comb begin
    w_inc = 1'b0;
    unique case (r_rm)
      2'b00:   w_inc = w_guard & (w_rs | w_mant[0]);
      2'b01:   w_inc = 1'b0;
      2'b10:   w_inc = r_sign & w_inexact;
      default: w_inc = ~r_sign & w_inexact;
    endcase
  end

  assign w_mant_r = {1'b0, w_mant} + {{(FRACW+1){1'b0}}, w_inc};
  assign w_exp_r  = w_exp_n + {{(EXPW+1){1'b0}}, w_mant_r[FRACW+1]};
  assign w_ovf    = ~w_exp_r[EXPW+1] & (w_exp_r >= c_emax);
  assign w_unf    = w_exp_r[EXPW+1] | (w_exp_r == '0);
  assign w_to_inf = (r_rm == 2'b00) | ((r_rm == 2'b10) & r_sign) | ((r_rm == 2'b11) & ~r_sign);

  always_comb begin
    w_res = {r_sign, w_exp_r[EXPW-1:0], w_mant_r[FRACW-1:0]};
    w_flg = {4'b0000, w_inexact};
    if (r_special) begin
      w_res = r_spec_res;
      w_flg = r_spec_flags;
    end else if (w_ovf) begin
      w_res = w_to_inf ? {r_sign, {EXPW{1'b1}}, {FRACW{1'b0}}}
                       : {r_sign, {(EXPW-1){1'b1}}, 1'b0, {FRACW{1'b1}}};
      w_flg = 5'b00101;
    end else if (w_unf) begin
      w_res = {r_sign, {(c_w-1){1'b0}}};
      w_flg = 5'b00011;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_PREP;
      S_PREP:  w_state_nxt = S_ITER;
      S_ITER:  if (r_cnt == c_last) w_state_nxt = S_ROUND;
      S_ROUND: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_rm         <= '0;
      r_cnt        <= '0;
      r_rem        <= '0;
      r_mb         <= '0;
      r_q          <= '0;
      r_exp        <= '0;
      r_sign       <= 1'b0;
      r_special    <= 1'b0;
      r_spec_res   <= '0;
      r_spec_flags <= '0;
      r_result     <= '0;
      r_flags      <= '0;
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: if (start) begin
          r_a  <= a;
          r_b  <= b;
          r_rm <= rm;
        end
        S_PREP: begin
          r_special    <= w_special;
          r_spec_res   <= w_spec_res;
          r_spec_flags <= w_spec_flags;
          r_sign       <= w_sign;
          r_exp        <= w_exp0;
          r_rem        <= {2'b01, w_fa};
          r_mb         <= {1'b1, w_fb};
          r_q          <= '0;
          r_cnt        <= '0;
        end
        S_ITER: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[c_n-2:0], w_ge};
          r_cnt <= r_cnt + c_cw'(1);
        end
        S_ROUND: begin
          r_result <= w_res;
          r_flags  <= w_flg;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state == S_PREP) | (r_state == S_ITER) | (r_state == S_ROUND);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign flags  = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_fpu_div_seq.sv
// Directed vector bench for fpu_div_seq in FP16 configuration.
`default_nettype none

module tb_fpu_div_seq;
  localparam int EXPW  = 5;
  localparam int FRACW = 10;
  localparam int W     = 16;
  localparam int N     = FRACW + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   rm = '0;
  logic         busy, done;
  logic [W-1:0] result;
  logic [4:0]   flags;

  fpu_div_seq #(.EXPW(EXPW), .FRACW(FRACW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .rm(rm),
    .busy(busy), .done(done), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the done cycle.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic [1:0] irm,
                        output logic [15:0] ores, output logic [4:0] oflg,
                        output int lat, output bit busy_ok);
    a = ia; b = ib; rm = irm; start = 1'b1;
    busy_ok = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; a = 16'hFFFF; b = 16'h0001; rm = 2'b01;
    lat = 1;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (lat > 100) begin lat = -1; break; end
      @(posedge clk);
      lat++;
    end
    ores = result;
    oflg = flags;
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  rm;
    logic [15:0] res;
    logic [4:0]  flg;
  } vec_t;

  vec_t        vecs[18];
  logic [15:0] r_res;
  logic [4:0]  r_flg;
  int          lat, extra;
  bit          bok, seen;

  initial begin
    vecs[0]  = '{16'h4600, 16'h4000, 2'd0, 16'h4200, 5'b00000};
    vecs[1]  = '{16'h3C00, 16'h4200, 2'd0, 16'h3555, 5'b00001};
    vecs[2]  = '{16'h3C00, 16'h4200, 2'd1, 16'h3555, 5'b00001};
    vecs[3]  = '{16'h3C00, 16'h4200, 2'd3, 16'h3556, 5'b00001};
    vecs[4]  = '{16'hBC00, 16'h4200, 2'd2, 16'hB556, 5'b00001};
    vecs[5]  = '{16'hBC00, 16'h4200, 2'd1, 16'hB555, 5'b00001};
    vecs[6]  = '{16'h3C00, 16'h0000, 2'd0, 16'h7C00, 5'b01000};
    vecs[7]  = '{16'h0000, 16'h0000, 2'd0, 16'h7E00, 5'b10000};
    vecs[8]  = '{16'h7D00, 16'h3C00, 2'd0, 16'h7E00, 5'b10000};
    vecs[9]  = '{16'h7E00, 16'h3C00, 2'd0, 16'h7E00, 5'b00000};
    vecs[10] = '{16'h7C00, 16'h4000, 2'd0, 16'h7C00, 5'b00000};
    vecs[11] = '{16'h3C00, 16'h7C00, 2'd0, 16'h0000, 5'b00000};
    vecs[12] = '{16'h7BFF, 16'h1400, 2'd0, 16'h7C00, 5'b00101};
    vecs[13] = '{16'h7BFF, 16'h1400, 2'd1, 16'h7BFF, 5'b00101};
    vecs[14] = '{16'h7BFF, 16'h1400, 2'd2, 16'h7BFF, 5'b00101};
    vecs[15] = '{16'h7BFF, 16'h1400, 2'd3, 16'h7C00, 5'b00101};
    vecs[16] = '{16'h0400, 16'h7800, 2'd0, 16'h0000, 5'b00011};
    vecs[17] = '{16'h0001, 16'hBC00, 2'd0, 16'h8000, 5'b00000};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_flags", flags, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, each started in the IDLE cycle right after the previous done
    for (int i = 0; i < 18; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].rm, r_res, r_flg, lat, bok);
      check($sformatf("vec%0d_result", i), r_res, vecs[i].res);
      check($sformatf("vec%0d_flags", i), r_flg, vecs[i].flg);
      check($sformatf("vec%0d_latency", i), lat, N + 3);
      check($sformatf("vec%0d_busy", i), bok, 1);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 0);
    end

    // start pulsed with fresh operands every cycle while busy
    a = 16'h4600; b = 16'h4000; rm = 2'd0; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin seen = 1'b1; start = 1'b0; break; end
      a = 16'($urandom); b = 16'($urandom); rm = 2'($urandom); start = 1'b1;
    end
    start = 1'b0;
    check("hs_done_seen", seen, 1);
    check("hs_result", result, 16'h4200);
    check("hs_flags", flags, 0);
    extra = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("hs_no_second_done", extra, 0);

    // Reset during the fifth ITER cycle aborts the operation
    a = 16'h3C00; b = 16'h4200; rm = 2'd0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_flags", flags, 0);
    extra = 0;
    repeat (3) begin @(negedge clk); if (done) extra++; end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("abort_no_done", extra, 0);
    run_op(16'h3C00, 16'h4200, 2'd3, r_res, r_flg, lat, bok);
    check("post_reset_result", r_res, 16'h3556);
    check("post_reset_flags", r_flg, 5'b00001);
    check("post_reset_latency", lat, N + 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
